// File: rtl/slave_arb_chan_if.sv
// slave_arb_chan_if: per-channel DDR write burst requester with frame wrap and partial final burst.
// Optional ping-pong bank selection when SLAVE_PINGPONG_EN is defined.
module slave_arb_chan_if #(
  parameter int ID_W = 2,
  parameter logic [ID_W-1:0] SLAVE_ID = '0,
  parameter int ADDR_W = 21,
  parameter int BLEN_W = 10,
  parameter int BURST_LEN = 256,
  parameter int MAX_ADDR = 245760,
  parameter int LEN_W = 11
) (
  input  logic                     ddr_clk,
  input  logic                     sys_rstn,
  input  logic                     fifo_full,
  input  logic [LEN_W-1:0]         fifo_len,
  input  logic                     frame_sync,
  output logic                     slave_req,
  input  logic                     arb_grant,
  output logic [ID_W+ADDR_W:0]     slave_waddr,
  output logic [BLEN_W-1:0]        slave_blen,
  output logic                     frame_done,
  output logic                     ovf_err,
  output logic                     rd_bank
);
  typedef enum logic [1:0] {IDLE, REQ, BUSY, DONE} state_t;
  localparam logic [ADDR_W:0] MAXV = (ADDR_W+1)'(MAX_ADDR);
  localparam logic [ADDR_W:0] BLV = (ADDR_W+1)'(BURST_LEN);
  state_t state, state_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic [ADDR_W:0] nxt;
  logic pend, wrap, sync_now, go, bank;
  function automatic logic [BLEN_W-1:0] blen_of(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] r;
    r = MAXV - {1'b0, a};
    return (r < BLV) ? BLEN_W'(r) : BLEN_W'(BURST_LEN);
  endfunction
  always_comb begin
    nxt = {1'b0, addr} + (ADDR_W+1)'(slave_blen);
    wrap = nxt >= MAXV;
    sync_now = (state == IDLE || state == DONE) && (frame_sync || pend);
    go = fifo_full || (32'(fifo_len) >= 32'(slave_blen));
    addr_d = (sync_now || (state == DONE && wrap)) ? '0 : (state == DONE) ? nxt[ADDR_W-1:0] : addr;
    state_d = (state == IDLE) ? (go ? REQ : IDLE) :
              (state == REQ)  ? (arb_grant ? BUSY : REQ) :
              (state == BUSY) ? (arb_grant ? BUSY : DONE) : IDLE;
  end
  always_ff @(posedge ddr_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state <= IDLE;
      addr <= '0;
      slave_blen <= blen_of('0);
      pend <= 1'b0;
      frame_done <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      state <= state_d;
      addr <= addr_d;
      slave_blen <= blen_of(addr_d);
      pend <= (state == REQ || state == BUSY) ? (pend | frame_sync) : (state == DONE) ? 1'b0 : pend;
      frame_done <= (state == DONE) && wrap;
      ovf_err <= ovf_err | (fifo_full && state != BUSY);
    end
  end
`ifdef SLAVE_PINGPONG_EN
  logic flip;
  assign flip = sync_now || (state == DONE && wrap);
  always_ff @(posedge ddr_clk or negedge sys_rstn) begin
    if (!sys_rstn) bank <= 1'b0;
    else bank <= bank ^ flip;
  end
  assign rd_bank = ~bank;
`else
  assign bank = 1'b0;
  assign rd_bank = 1'b0;
`endif
  assign slave_req = state == REQ;
  assign slave_waddr = {SLAVE_ID, bank, addr};
endmodule

// File: tb/tb_slave_arb_chan_if.sv
// tb_slave_arb_chan_if: directed checks of request, address wrap, partial burst, frame_sync and overflow.
module tb_slave_arb_chan_if;
`ifdef SLAVE_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif
  logic ddr_clk = 0, sys_rstn = 0, fifo_full = 0, frame_sync = 0, grant0 = 0, grant1 = 0;
  logic [10:0] fifo_len = 0;
  logic req0, fd0, ovf0, rdb0, req1, fd1, ovf1, rdb1;
  logic [23:0] waddr0, waddr1;
  logic [9:0] blen0, blen1;
  logic bank_exp = 0;
  int tests = 0, fails = 0;
  always #5 ddr_clk = ~ddr_clk;
  slave_arb_chan_if #(.SLAVE_ID(2'd2)) u0 (
    .ddr_clk(ddr_clk), .sys_rstn(sys_rstn), .fifo_full(fifo_full), .fifo_len(fifo_len),
    .frame_sync(frame_sync), .slave_req(req0), .arb_grant(grant0), .slave_waddr(waddr0),
    .slave_blen(blen0), .frame_done(fd0), .ovf_err(ovf0), .rd_bank(rdb0));
  slave_arb_chan_if #(.SLAVE_ID(2'd0), .MAX_ADDR(1000)) u1 (
    .ddr_clk(ddr_clk), .sys_rstn(sys_rstn), .fifo_full(fifo_full), .fifo_len(fifo_len),
    .frame_sync(frame_sync), .slave_req(req1), .arb_grant(grant1), .slave_waddr(waddr1),
    .slave_blen(blen1), .frame_done(fd1), .ovf_err(ovf1), .rd_bank(rdb1));
  task automatic burst0(input logic [20:0] ea, input logic sync_busy, output logic fd);
    int n = 0;
    while (req0 !== 1'b1 && n < 50) begin @(negedge ddr_clk); n++; end
    tests++; if (req0 !== 1'b1) begin fails++; $display("FAIL req_timeout0: got %b want 1", req0); end
    tests++; if (waddr0 !== {2'd2, bank_exp, ea}) begin fails++; $display("FAIL burst_waddr0: got %h want %h", waddr0, {2'd2, bank_exp, ea}); end
    tests++; if (blen0 !== 10'd256) begin fails++; $display("FAIL burst_blen0: got %0d want 256", blen0); end
    tests++; if (rdb0 !== (PP & ~bank_exp)) begin fails++; $display("FAIL burst_rdbank0: got %b want %b", rdb0, PP & ~bank_exp); end
    grant0 = 1; @(negedge ddr_clk);
    tests++; if (req0 !== 1'b0) begin fails++; $display("FAIL burst_req_drop0: got %b want 0", req0); end
    grant0 = 0; frame_sync = sync_busy; @(negedge ddr_clk);
    frame_sync = 0; @(negedge ddr_clk);
    fd = fd0;
  endtask
  task automatic burst1(input logic [20:0] ea, input logic [9:0] eb, output logic fd);
    int n = 0;
    while (req1 !== 1'b1 && n < 50) begin @(negedge ddr_clk); n++; end
    tests++; if (req1 !== 1'b1) begin fails++; $display("FAIL req_timeout1: got %b want 1", req1); end
    tests++; if (waddr1 !== {3'd0, ea}) begin fails++; $display("FAIL burst_waddr1: got %h want %h", waddr1, {3'd0, ea}); end
    tests++; if (blen1 !== eb) begin fails++; $display("FAIL burst_blen1: got %0d want %0d", blen1, eb); end
    grant1 = 1; @(negedge ddr_clk);
    grant1 = 0; @(negedge ddr_clk);
    @(negedge ddr_clk);
    fd = fd1;
  endtask
  task automatic test_reset();
    repeat (2) @(negedge ddr_clk);
    tests++; if (req0 !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", req0); end
    tests++; if (fd0 !== 1'b0) begin fails++; $display("FAIL rst_fd: got %b want 0", fd0); end
    tests++; if (ovf0 !== 1'b0) begin fails++; $display("FAIL rst_ovf: got %b want 0", ovf0); end
    tests++; if (blen0 !== 10'd256) begin fails++; $display("FAIL rst_blen0: got %0d want 256", blen0); end
    tests++; if (blen1 !== 10'd256) begin fails++; $display("FAIL rst_blen1: got %0d want 256", blen1); end
    tests++; if (waddr0 !== 24'h800000) begin fails++; $display("FAIL rst_waddr0: got %h want 800000", waddr0); end
    tests++; if (rdb0 !== PP) begin fails++; $display("FAIL rst_rdbank: got %b want %b", rdb0, PP); end
    sys_rstn = 1; @(negedge ddr_clk);
  endtask
  task automatic test_grant_idle();
    grant0 = 1; repeat (2) @(negedge ddr_clk);
    grant0 = 0; @(negedge ddr_clk);
    tests++; if (req0 !== 1'b0) begin fails++; $display("FAIL idle_grant_req: got %b want 0", req0); end
    tests++; if (waddr0 !== 24'h800000) begin fails++; $display("FAIL idle_grant_addr: got %h want 800000", waddr0); end
  endtask
  task automatic test_threshold();
    fifo_len = 255; repeat (2) @(negedge ddr_clk);
    tests++; if (req0 !== 1'b0) begin fails++; $display("FAIL below_thr: got %b want 0", req0); end
    fifo_len = 256; @(negedge ddr_clk);
    tests++; if (req0 !== 1'b1) begin fails++; $display("FAIL req_rise: got %b want 1", req0); end
    tests++; if (waddr0 !== 24'h800000) begin fails++; $display("FAIL t1_waddr: got %h want 800000", waddr0); end
    tests++; if (blen0 !== 10'd256) begin fails++; $display("FAIL t1_blen: got %0d want 256", blen0); end
    fifo_len = 0; @(negedge ddr_clk);
    tests++; if (req0 !== 1'b1) begin fails++; $display("FAIL req_hold: got %b want 1", req0); end
    grant0 = 1; @(negedge ddr_clk);
    tests++; if (req0 !== 1'b0) begin fails++; $display("FAIL req_drop: got %b want 0", req0); end
    grant0 = 0; repeat (2) @(negedge ddr_clk);
    tests++; if (waddr0 !== 24'h800100) begin fails++; $display("FAIL t1_next_addr: got %h want 800100", waddr0); end
    tests++; if (fd0 !== 1'b0) begin fails++; $display("FAIL t1_fd: got %b want 0", fd0); end
  endtask
  task automatic test_partial();
    logic [20:0] ea [4] = '{21'd0, 21'd256, 21'd512, 21'd768};
    logic [9:0] eb [4] = '{10'd256, 10'd256, 10'd256, 10'd232};
    logic fd;
    fifo_len = 300;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) fifo_len = 232;
      burst1(ea[i], eb[i], fd);
      tests++; if (fd !== (i == 3)) begin fails++; $display("FAIL t3_fd[%0d]: got %b want %b", i, fd, i == 3); end
    end
    tests++; if (waddr1[20:0] !== 21'd0) begin fails++; $display("FAIL t3_wrap_addr: got %h want 0", waddr1[20:0]); end
    tests++; if (blen1 !== 10'd256) begin fails++; $display("FAIL t3_wrap_blen: got %0d want 256", blen1); end
    fifo_len = 0; @(negedge ddr_clk);
    tests++; if (fd1 !== 1'b0) begin fails++; $display("FAIL t3_fd_pulse: got %b want 0", fd1); end
  endtask
  task automatic test_ovf();
    logic fd;
    burst0(21'd256, 1'b0, fd);
    tests++; if (ovf0 !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b want 0", ovf0); end
    fifo_full = 1; @(negedge ddr_clk);
    fifo_full = 0;
    tests++; if (ovf0 !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b want 1", ovf0); end
    tests++; if (req0 !== 1'b1) begin fails++; $display("FAIL ovf_req: got %b want 1", req0); end
    repeat (3) @(negedge ddr_clk);
    tests++; if (ovf0 !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", ovf0); end
    burst0(21'd512, 1'b0, fd);
    tests++; if (ovf0 !== 1'b1) begin fails++; $display("FAIL ovf_sticky2: got %b want 1", ovf0); end
  endtask
  task automatic test_sync_busy();
    logic fd;
    frame_sync = 1; @(negedge ddr_clk);
    frame_sync = 0;
    if (PP) bank_exp = ~bank_exp;
    tests++; if (waddr0 !== {2'd2, bank_exp, 21'd0}) begin fails++; $display("FAIL sync_idle_addr: got %h want %h", waddr0, {2'd2, bank_exp, 21'd0}); end
    tests++; if (fd0 !== 1'b0) begin fails++; $display("FAIL sync_idle_fd: got %b want 0", fd0); end
    fifo_len = 300;
    burst0(21'd0, 1'b0, fd);
    burst0(21'd256, 1'b0, fd);
    burst0(21'd512, 1'b1, fd);
    tests++; if (fd !== 1'b0) begin fails++; $display("FAIL t4_fd: got %b want 0", fd); end
    if (PP) bank_exp = ~bank_exp;
  endtask
  task automatic test_wrap();
    logic fd;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 960; i++) begin
        burst0(21'(i * 256), 1'b0, fd);
        tests++; if (fd !== (i == 959)) begin fails++; $display("FAIL wrap_fd[%0d.%0d]: got %b want %b", f, i, fd, i == 959); end
      end
      if (PP) bank_exp = ~bank_exp;
      tests++; if (waddr0 !== {2'd2, bank_exp, 21'd0}) begin fails++; $display("FAIL wrap_addr[%0d]: got %h want %h", f, waddr0, {2'd2, bank_exp, 21'd0}); end
      tests++; if (rdb0 !== (PP & ~bank_exp)) begin fails++; $display("FAIL wrap_rdbank[%0d]: got %b want %b", f, rdb0, PP & ~bank_exp); end
      @(negedge ddr_clk);
      tests++; if (fd0 !== 1'b0) begin fails++; $display("FAIL wrap_fd_pulse[%0d]: got %b want 0", f, fd0); end
    end
  endtask
  task automatic test_reset_busy();
    int n = 0;
    while (req0 !== 1'b1 && n < 50) begin @(negedge ddr_clk); n++; end
    tests++; if (req0 !== 1'b1) begin fails++; $display("FAIL rb_req_timeout: got %b want 1", req0); end
    grant0 = 1; @(negedge ddr_clk);
    sys_rstn = 0; #1;
    tests++; if (req0 !== 1'b0) begin fails++; $display("FAIL rb_req: got %b want 0", req0); end
    tests++; if (waddr0 !== 24'h800000) begin fails++; $display("FAIL rb_waddr: got %h want 800000", waddr0); end
    tests++; if (rdb0 !== PP) begin fails++; $display("FAIL rb_rdbank: got %b want %b", rdb0, PP); end
    grant0 = 0; fifo_len = 0; bank_exp = 0;
    @(negedge ddr_clk);
    sys_rstn = 1; repeat (2) @(negedge ddr_clk);
    tests++; if (req0 !== 1'b0) begin fails++; $display("FAIL rb_idle: got %b want 0", req0); end
    fifo_len = 300; @(negedge ddr_clk);
    tests++; if (req0 !== 1'b1) begin fails++; $display("FAIL rb_req_again: got %b want 1", req0); end
  endtask
  initial begin
    test_reset();
    test_grant_idle();
    test_threshold();
    test_partial();
    test_ovf();
    test_sync_busy();
    test_wrap();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
